mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer/counter peripheral on the core's data bus, behind the MMU's peripheral bank decode. Provides a 64-bit prescaled cycle timer (`mtime`), a 64-bit compare register (`mtimecmp`) with a sticky pending flag and level interrupt, and a 64-bit retired-instruction counter. Coherent 64-bit reads use a high-word snapshot. Read data is combinational so the multicycle core can latch it in its memory-read state.

## Interface
- `ADDR_W`, default 8: width of the bank-relative byte offset.
- `PRESCALE_RESET`, default 8'd0: reset value of `CTRL.prescale`.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `sel`  in  1: bank select from the MMU; access valid this cycle.
- `addr`  in  ADDR_W: byte offset within the bank.
- `access`  in  `mem_access_t`: byte, half or word.
- `wr_ena`  in  1: write strobe; committed at the `clk` edge when `sel` is high.
- `wr_data`  in  32: write data.
- `instruction_done`  in  1: one-cycle retire pulse from the core.
- `rd_data`  out  32: combinational read data; 0 when not selected or on fault.
- `fault`  out  1: combinational; the MMU maps it into the exception mask.
- `irq`  out  1: registered interrupt, high when `STATUS.pending` and `CTRL.irq_en` are both set.

## Operation
- Register map (word offsets):
  - 0x00 `MTIME_LO` (RW)
  - 0x04 `MTIME_HI` (RW write; reads return the shadow)
  - 0x08 `MTIMECMP_LO` (RW)
  - 0x0C `MTIMECMP_HI` (RW)
  - 0x10 `CTRL` (RW): bit0 `en`, bit1 `irq_en`, bits 15:8 `prescale`; all other bits read 0
  - 0x14 `STATUS`: bit0 `pending`, write-1-to-clear
  - 0x18 `INSTRET_LO` (RO)
  - 0x1C `INSTRET_HI` (RO, reads return the shadow)
- Fault conditions: `sel` with any of
  - non-word access,
  - `addr[1:0]` ≠ 0,
  - offset ≥ 0x20,
  - a write to a read-only offset.
- On fault: `rd_data` = 0, no state changes, no shadow capture.
- Prescaler: an 8-bit counter runs while `en`=1. When it equals `prescale`, it reloads to 0 and issues one tick. Each tick increments `mtime` by 1 (mod 2^64). While `en`=0 the prescaler holds at 0.
- Compare:
  - `pending` sets on any cycle where `en`=1 and `mtime` ≥ `mtimecmp` (unsigned 64-bit).
  - `pending` is sticky until cleared by a write-1 to `STATUS`.
  - If the set condition and the clear occur in the same cycle, set wins.
- Snapshot:
  - A successful read of `MTIME_LO` captures `mtime[63:32]` into `mtime_hi_shadow` at that clock edge.
  - A read of `INSTRET_LO` likewise captures `instret[63:32]` into its shadow.
  - The HI reads return the shadow values.
- Write vs. increment: a software write to `MTIME_LO`/`MTIME_HI` replaces that half and overrides the tick in the same cycle. The other half keeps its pre-write value; there is no carry from a concurrent tick.
- `instret` increments by 1 on each `instruction_done` pulse (mod 2^64).
- Reset values:
  - `mtime`, `instret`, both shadows, `pending`, `irq`: 0
  - `mtimecmp`: all ones
  - `CTRL`: `en`=0, `irq_en`=0, `prescale`=`PRESCALE_RESET`
  - `rd_data`, `fault` follow the inputs; both are 0 when `sel`=0.

## Timing
- Read latency is 0: `rd_data` is valid in the same cycle as `sel`/`addr`.
- Writes take effect at the next rising `clk` edge and are visible to reads in the following cycle.
- With `prescale`=P, `mtime` advances once every P+1 cycles. The first tick comes P+1 cycles after `en` is written to 1.
- `pending` is registered: it is visible 1 cycle after the compare condition holds. `irq` follows 1 cycle after that, so 2 cycles from condition to `irq`.
- `rst` asserted mid-access dominates: the write is dropped and all state returns to reset values on that edge.

## Configuration
- Macro: `MMIO_TIMER_INSTRET_EN`.
- Defined: the `instret` counter and its shadow are built; 0x18 and 0x1C behave as specified above.
- Undefined: no `instret` logic is built. `instruction_done` is ignored. 0x18 and 0x1C read 0 without fault, and writes to them still fault.

## Structure
- The shared package `mmio_timer_pkg` holds:
  - offset constants: `MMIO_TIMER_OFF_MTIME_LO` … `MMIO_TIMER_OFF_INSTRET_HI`
  - CTRL bit/field positions
  - a `mmio_timer_ctrl_t` packed struct
- `mem_access_t` is used from the existing memory-access definitions.
- One sub-module: `counter64_shadow`, which implements the 64-bit counter, LO/HI write override and the snapshot register. It is instantiated for `mtime` and, when `MMIO_TIMER_INSTRET_EN` is defined, for `instret`.

## Test plan
- Reset, then read all eight offsets → 0 everywhere except `MTIMECMP_LO`/`HI` = 0xFFFF_FFFF; `irq`=0.
- Write `CTRL`=0x0000_0301 (`prescale`=3, `en`=1) and wait 40 cycles → `MTIME_LO` reads 10.
- Write `MTIME_LO`=0xFFFF_FFFF, `MTIME_HI`=0, `prescale`=0, `en`=1. Read LO then HI across the wrap → the HI value matches the shadow taken with LO (LO=0xFFFF_FFFF paired with HI=0, or LO=0 paired with HI=1), never mixed.
- Set `mtimecmp`=5, `irq_en`=1, `en`=1, `prescale`=0 → `pending` and `irq` rise. Write `STATUS`=1 while `mtime` ≥ 5 → `pending` stays 1 (set wins). Set `mtimecmp` to all ones, then write 1 → `irq` drops 1 cycle later.
- Half-word read at 0x00, word read at 0x02, word access at 0x24, write to 0x18 → `fault`=1, `rd_data`=0, no state change.
- Pulse `instruction_done` 7 times → `INSTRET_LO`=7 with the macro defined; 0 without it.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the mmio_timer peripheral: access type, register
// offsets, CTRL field layout and the CTRL register struct.
package mmio_timer_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_access_t;

    localparam int unsigned MMIO_TIMER_DATA_W = 32;
    localparam int unsigned MMIO_TIMER_OFF_W  = 5;

    localparam logic [MMIO_TIMER_OFF_W-1:0] MMIO_TIMER_OFF_MTIME_LO    = 5'h00;
    localparam logic [MMIO_TIMER_OFF_W-1:0] MMIO_TIMER_OFF_MTIME_HI    = 5'h04;
    localparam logic [MMIO_TIMER_OFF_W-1:0] MMIO_TIMER_OFF_MTIMECMP_LO = 5'h08;
    localparam logic [MMIO_TIMER_OFF_W-1:0] MMIO_TIMER_OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [MMIO_TIMER_OFF_W-1:0] MMIO_TIMER_OFF_CTRL        = 5'h10;
    localparam logic [MMIO_TIMER_OFF_W-1:0] MMIO_TIMER_OFF_STATUS      = 5'h14;
    localparam logic [MMIO_TIMER_OFF_W-1:0] MMIO_TIMER_OFF_INSTRET_LO  = 5'h18;
    localparam logic [MMIO_TIMER_OFF_W-1:0] MMIO_TIMER_OFF_INSTRET_HI  = 5'h1C;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;
    localparam int unsigned CTRL_PRESCALE_W   = 8;
    localparam int unsigned STATUS_PENDING_BIT = 0;

    typedef struct packed {
        logic [CTRL_PRESCALE_W-1:0] prescale;
        logic                       irq_en;
        logic                       en;
    } mmio_timer_ctrl_t;

    // Software view of CTRL: unused bits read as zero.
    function automatic logic [MMIO_TIMER_DATA_W-1:0] mmio_timer_ctrl_word(mmio_timer_ctrl_t c);
        logic [MMIO_TIMER_DATA_W-1:0] w;
        w = '0;
        w[CTRL_EN_BIT]                                  = c.en;
        w[CTRL_IRQ_EN_BIT]                              = c.irq_en;
        w[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W]         = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Peripheral-bank bus between the MMU decode (master) and mmio_timer (slave).
interface mmio_timer_if #(
    parameter int unsigned ADDR_W = 8
);
    import mmio_timer_pkg::*;

    logic                 sel;
    logic [ADDR_W-1:0]    addr;
    mem_access_t          access;
    logic                 wr_ena;
    logic [31:0]          wr_data;
    logic [31:0]          rd_data;
    logic                 fault;

    modport master (output sel, addr, access, wr_ena, wr_data, input rd_data, fault);
    modport slave  (input sel, addr, access, wr_ena, wr_data, output rd_data, fault);

endinterface

// File: rtl/counter64_shadow.sv
// 64-bit free-running counter with per-half software write (write beats
// increment) and a high-word snapshot taken alongside a low-word read.
module counter64_shadow (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_data_i,
    input  logic        snap_i,
    output logic [63:0] count_o,
    output logic [31:0] shadow_o
);

    logic [63:0] count_q, count_d;
    logic [31:0] shadow_q, shadow_d;

    // Next count: a write replaces its half only; no carry from a concurrent tick.
    always_comb begin
        count_d  = count_q;
        shadow_d = shadow_q;
        if (wr_lo_i) begin
            count_d = {count_q[63:32], wr_data_i};
        end else if (wr_hi_i) begin
            count_d = {wr_data_i, count_q[31:0]};
        end else if (inc_i) begin
            count_d = count_q + 64'd1;
        end
        if (snap_i) begin
            shadow_d = count_q[63:32];
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            count_q  <= count_d;
            shadow_q <= shadow_d;
        end
    end

    assign count_o  = count_q;
    assign shadow_o = shadow_q;

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer: prescaled 64-bit mtime, 64-bit compare with sticky
// pending flag and level irq, optional retired-instruction counter.
// Build option: define MMIO_TIMER_INSTRET_EN to include the instret counter.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter logic [7:0]  PRESCALE_RESET = 8'd0
) (
    input  logic          clk,
    input  logic          rst,
    mmio_timer_if.slave   bus,
    input  logic          instruction_done,
    output logic          irq
);

    logic [MMIO_TIMER_OFF_W-1:0] off_c;
    logic                        in_range_c;
    logic                        ro_c;
    logic                        fault_c;
    logic                        ok_c;
    logic                        wr_c;
    logic                        rd_c;

    mmio_timer_ctrl_t ctrl_q, ctrl_d;
    logic [63:0]      cmp_q, cmp_d;
    logic [7:0]       presc_q, presc_d;
    logic             tick_c;
    logic             pending_q, pending_d;
    logic             irq_q, irq_d;

    logic [63:0]      mtime_c;
    logic [31:0]      mtime_hi_sh_c;
    logic [31:0]      instret_lo_c;
    logic [31:0]      instret_hi_sh_c;
    logic [31:0]      rd_data_c;

    // Address decode and fault detection.
    assign off_c      = bus.addr[MMIO_TIMER_OFF_W-1:0];
    assign in_range_c = (bus.addr[ADDR_W-1:MMIO_TIMER_OFF_W] == '0);
    assign ro_c       = (off_c == MMIO_TIMER_OFF_INSTRET_LO) || (off_c == MMIO_TIMER_OFF_INSTRET_HI);
    assign fault_c    = bus.sel && ((bus.access != MEM_WORD) || (off_c[1:0] != 2'b00) ||
                                    !in_range_c || (bus.wr_ena && ro_c));
    assign ok_c       = bus.sel && !fault_c;
    assign wr_c       = ok_c && bus.wr_ena;
    assign rd_c       = ok_c && !bus.wr_ena;

    counter64_shadow u_mtime (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (tick_c),
        .wr_lo_i   (wr_c && (off_c == MMIO_TIMER_OFF_MTIME_LO)),
        .wr_hi_i   (wr_c && (off_c == MMIO_TIMER_OFF_MTIME_HI)),
        .wr_data_i (bus.wr_data),
        .snap_i    (rd_c && (off_c == MMIO_TIMER_OFF_MTIME_LO)),
        .count_o   (mtime_c),
        .shadow_o  (mtime_hi_sh_c)
    );

`ifdef MMIO_TIMER_INSTRET_EN
    logic [63:0] instret_c;
    logic [31:0] unused_instret_hi;

    counter64_shadow u_instret (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (instruction_done),
        .wr_lo_i   (1'b0),
        .wr_hi_i   (1'b0),
        .wr_data_i (bus.wr_data),
        .snap_i    (rd_c && (off_c == MMIO_TIMER_OFF_INSTRET_LO)),
        .count_o   (instret_c),
        .shadow_o  (instret_hi_sh_c)
    );

    assign instret_lo_c      = instret_c[31:0];
    assign unused_instret_hi = instret_c[63:32];
`else
    logic unused_instruction_done;

    assign instret_lo_c            = '0;
    assign instret_hi_sh_c         = '0;
    assign unused_instruction_done = instruction_done;
`endif

    // Next-state for prescaler, CTRL, compare, pending and irq.
    always_comb begin
        presc_d   = presc_q;
        tick_c    = 1'b0;
        ctrl_d    = ctrl_q;
        cmp_d     = cmp_q;
        pending_d = pending_q;
        irq_d     = pending_q && ctrl_q.irq_en;

        if (!ctrl_q.en) begin
            presc_d = '0;
        end else if (presc_q == ctrl_q.prescale) begin
            presc_d = '0;
            tick_c  = 1'b1;
        end else begin
            presc_d = presc_q + 8'd1;
        end

        if (wr_c && (off_c == MMIO_TIMER_OFF_CTRL)) begin
            ctrl_d.en       = bus.wr_data[CTRL_EN_BIT];
            ctrl_d.irq_en   = bus.wr_data[CTRL_IRQ_EN_BIT];
            ctrl_d.prescale = bus.wr_data[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W];
        end
        if (wr_c && (off_c == MMIO_TIMER_OFF_MTIMECMP_LO)) begin
            cmp_d[31:0] = bus.wr_data;
        end
        if (wr_c && (off_c == MMIO_TIMER_OFF_MTIMECMP_HI)) begin
            cmp_d[63:32] = bus.wr_data;
        end

        // Clear first so that a same-cycle compare hit wins.
        if (wr_c && (off_c == MMIO_TIMER_OFF_STATUS) && bus.wr_data[STATUS_PENDING_BIT]) begin
            pending_d = 1'b0;
        end
        if (ctrl_q.en && (mtime_c >= cmp_q)) begin
            pending_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            ctrl_q    <= mmio_timer_ctrl_t'{prescale: PRESCALE_RESET, irq_en: 1'b0, en: 1'b0};
            cmp_q     <= '1;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            ctrl_q    <= ctrl_d;
            cmp_q     <= cmp_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    // Zero-latency read mux.
    always_comb begin
        rd_data_c = '0;
        if (ok_c) begin
            case (off_c)
                MMIO_TIMER_OFF_MTIME_LO:    rd_data_c = mtime_c[31:0];
                MMIO_TIMER_OFF_MTIME_HI:    rd_data_c = mtime_hi_sh_c;
                MMIO_TIMER_OFF_MTIMECMP_LO: rd_data_c = cmp_q[31:0];
                MMIO_TIMER_OFF_MTIMECMP_HI: rd_data_c = cmp_q[63:32];
                MMIO_TIMER_OFF_CTRL:        rd_data_c = mmio_timer_ctrl_word(ctrl_q);
                MMIO_TIMER_OFF_STATUS:      rd_data_c = {31'd0, pending_q};
                MMIO_TIMER_OFF_INSTRET_LO:  rd_data_c = instret_lo_c;
                MMIO_TIMER_OFF_INSTRET_HI:  rd_data_c = instret_hi_sh_c;
                default:                    rd_data_c = '0;
            endcase
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.fault   = fault_c;
    assign irq         = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboarded bench for mmio_timer: the driver pushes expected bus responses,
// a negedge monitor pops and compares whenever the bus is selected.
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam int unsigned ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic instruction_done;
    logic irq;

    mmio_timer_if #(.ADDR_W(ADDR_W)) bus ();

    mmio_timer #(.ADDR_W(ADDR_W), .PRESCALE_RESET(8'd0)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .instruction_done (instruction_done),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    string       q_name [$];
    logic [31:0] q_rd   [$];
    logic        q_flt  [$];
    logic        q_irq  [$];

    // Reference model: mtime is derived from elapsed edges since enable.
    longint unsigned n = 0;
    logic [63:0]     m_v;
    longint unsigned m_nb, m_n0;
    bit              m_en, m_irqen, m_pend, m_irq;
    logic [7:0]      m_p;
    logic [63:0]     m_cmp;
    logic [31:0]     m_mhi, m_ihi;
    logic [63:0]     m_instret;

    task automatic model_reset();
        m_v = '0; m_nb = n; m_n0 = n; m_en = 0; m_irqen = 0; m_pend = 0; m_irq = 0;
        m_p = 8'd0; m_cmp = '1; m_mhi = '0; m_ihi = '0; m_instret = '0;
    endtask

    function automatic logic [63:0] mt_at(longint unsigned k);
        longint unsigned div;
        if (!m_en) return m_v;
        div = longint'(m_p) + 1;
        return m_v + 64'((k - m_n0) / div - (m_nb - m_n0) / div);
    endfunction

    function automatic bit fault_f(bit s, logic [7:0] a, mem_access_t acc, bit w);
        return s && ((acc != MEM_WORD) || (a[1:0] != 2'b00) || (a >= 8'h20) ||
                     (w && (a == 8'h18 || a == 8'h1C)));
    endfunction

    function automatic logic [31:0] rd_model(bit s, logic [7:0] a, mem_access_t acc, bit w);
        logic [63:0] cur;
        cur = mt_at(n);
        if (!s || fault_f(s, a, acc, w)) return 32'd0;
        case (a)
            8'h00: return cur[31:0];
            8'h04: return m_mhi;
            8'h08: return m_cmp[31:0];
            8'h0C: return m_cmp[63:32];
            8'h10: return {16'd0, m_p, 6'd0, m_irqen, m_en};
            8'h14: return {31'd0, m_pend};
`ifdef MMIO_TIMER_INSTRET_EN
            8'h18: return m_instret[31:0];
            8'h1C: return m_ihi;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Apply the cycle's inputs to the model at the clock edge.
    task automatic model_edge();
        logic [63:0] cur, nxt;
        logic [7:0]  a;
        logic [31:0] d;
        bit ok, w, set, pend_n, irq_n;
        if (rst) begin
            model_reset();
        end else begin
            a   = bus.addr;
            d   = bus.wr_data;
            w   = bus.wr_ena;
            cur = mt_at(n);
            nxt = mt_at(n + 1);
            ok  = bus.sel && !fault_f(bus.sel, a, bus.access, w);
            set = m_en && (cur >= m_cmp);
            irq_n  = m_pend && m_irqen;
            pend_n = set || (m_pend && !(ok && w && a == 8'h14 && d[0]));
            if (ok && !w && a == 8'h00) m_mhi = cur[63:32];
`ifdef MMIO_TIMER_INSTRET_EN
            if (ok && !w && a == 8'h18) m_ihi = m_instret[63:32];
            if (instruction_done) m_instret = m_instret + 64'd1;
`endif
            if (ok && w) begin
                case (a)
                    8'h00: begin m_v = {cur[63:32], d}; m_nb = n + 1; end
                    8'h04: begin m_v = {d, cur[31:0]}; m_nb = n + 1; end
                    8'h08: m_cmp[31:0]  = d;
                    8'h0C: m_cmp[63:32] = d;
                    8'h10: begin
                        m_v  = nxt;
                        m_nb = n + 1;
                        if (d[0] && !m_en) m_n0 = n + 1;
                        m_en    = d[0];
                        m_irqen = d[1];
                        m_p     = d[15:8];
                    end
                    default: ;
                endcase
            end
            m_pend = pend_n;
            m_irq  = irq_n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        n++;
        #1;
    endtask

    task automatic idle(int cycles, bit rnd_idone);
        for (int i = 0; i < cycles; i++) begin
            instruction_done = rnd_idone ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        instruction_done = 1'b0;
    endtask

    task automatic pulse_idone(int count);
        for (int i = 0; i < count; i++) begin
            instruction_done = 1'b1;
            tick();
            instruction_done = 1'b0;
        end
    endtask

    // One bus access lasting a single cycle; use_c selects constant expectations.
    task automatic access(string name, bit w, logic [7:0] a, mem_access_t acc, logic [31:0] d,
                          bit use_c, logic [31:0] c_rd, bit c_irq);
        bus.sel     = 1'b1;
        bus.wr_ena  = w;
        bus.addr    = a;
        bus.access  = acc;
        bus.wr_data = d;
        q_name.push_back(name);
        q_rd.push_back(use_c ? c_rd : rd_model(1'b1, a, acc, w));
        q_flt.push_back(fault_f(1'b1, a, acc, w));
        q_irq.push_back(use_c ? c_irq : m_irq);
        tick();
        bus.sel          = 1'b0;
        bus.wr_ena       = 1'b0;
        instruction_done = 1'b0;
    endtask

    task automatic wr(string name, logic [7:0] a, logic [31:0] d);
        access(name, 1'b1, a, MEM_WORD, d, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic rd_const(string name, logic [7:0] a, logic [31:0] exp_rd, bit exp_irq);
        access(name, 1'b0, a, MEM_WORD, 32'd0, 1'b1, exp_rd, exp_irq);
    endtask

    task automatic rd(string name, logic [7:0] a);
        access(name, 1'b0, a, MEM_WORD, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    // Monitor: compare every selected cycle against the scoreboard head.
    initial begin
        string       nm;
        logic [31:0] erd;
        logic        ef, ei;
        forever begin
            @(negedge clk);
            if (bus.sel === 1'b1) begin
                checks++;
                if (q_name.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_access: rd_data=%h fault=%b with empty scoreboard",
                             bus.rd_data, bus.fault);
                end else begin
                    nm  = q_name.pop_front();
                    erd = q_rd.pop_front();
                    ef  = q_flt.pop_front();
                    ei  = q_irq.pop_front();
                    if (bus.rd_data !== erd || bus.fault !== ef || irq !== ei) begin
                        failures++;
                        $display("FAIL %s: got rd_data=%h fault=%b irq=%b, expected rd_data=%h fault=%b irq=%b",
                                 nm, bus.rd_data, bus.fault, irq, erd, ef, ei);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        mem_access_t acc;
        bit          w;
        logic [31:0] exp_instret;

        rst              = 1'b1;
        instruction_done = 1'b0;
        bus.sel          = 1'b0;
        bus.wr_ena       = 1'b0;
        bus.addr         = '0;
        bus.access       = MEM_WORD;
        bus.wr_data      = '0;
        model_reset();
        idle(3, 1'b0);
        rst = 1'b0;

        // Reset values of all registers.
        rd_const("rst_mtime_lo",   8'h00, 32'h0,         1'b0);
        rd_const("rst_mtime_hi",   8'h04, 32'h0,         1'b0);
        rd_const("rst_cmp_lo",     8'h08, 32'hFFFF_FFFF, 1'b0);
        rd_const("rst_cmp_hi",     8'h0C, 32'hFFFF_FFFF, 1'b0);
        rd_const("rst_ctrl",       8'h10, 32'h0,         1'b0);
        rd_const("rst_status",     8'h14, 32'h0,         1'b0);
        rd_const("rst_instret_lo", 8'h18, 32'h0,         1'b0);
        rd_const("rst_instret_hi", 8'h1C, 32'h0,         1'b0);

        // prescale=3: one tick every 4 cycles, 40 cycles -> 10.
        wr("ctrl_p3", 8'h10, 32'h0000_0301);
        idle(40, 1'b0);
        rd_const("prescale3_40cyc", 8'h00, 32'd10, 1'b0);

        // Coherent 64-bit read across the low-word wrap.
        wr("ctrl_off", 8'h10, 32'h0);
        wr("mtime_lo_wrap", 8'h00, 32'hFFFF_FFFF);
        wr("mtime_hi_wrap", 8'h04, 32'h0);
        wr("ctrl_p0", 8'h10, 32'h0000_0001);
        rd_const("wrap_lo", 8'h00, 32'hFFFF_FFFF, 1'b0);
        rd_const("wrap_hi", 8'h04, 32'h0,         1'b0);
        for (int i = 0; i < 3; i++) begin
            rd("wrap_lo_n", 8'h00);
            rd("wrap_hi_n", 8'h04);
        end

        // Compare, sticky pending, set-wins-over-clear, irq drop timing.
        wr("ctrl_off2", 8'h10, 32'h0);
        wr("mtime_lo0", 8'h00, 32'h0);
        wr("mtime_hi0", 8'h04, 32'h0);
        wr("cmp_hi0",   8'h0C, 32'h0);
        wr("cmp_lo5",   8'h08, 32'd5);
        wr("ctrl_irq",  8'h10, 32'h0000_0003);
        idle(10, 1'b0);
        rd_const("pending_set",    8'h14, 32'd1, 1'b1);
        wr("status_clr_setwins", 8'h14, 32'd1);
        rd_const("pending_setwins", 8'h14, 32'd1, 1'b1);
        wr("cmp_lo_max", 8'h08, 32'hFFFF_FFFF);
        wr("cmp_hi_max", 8'h0C, 32'hFFFF_FFFF);
        wr("status_clr", 8'h14, 32'd1);
        rd_const("pending_clr_irq_hold", 8'h14, 32'd0, 1'b1);
        rd_const("pending_clr_irq_drop", 8'h14, 32'd0, 1'b0);

        // Faulting accesses leave state untouched.
        access("fault_half_rd",  1'b0, 8'h00, MEM_HALF, 32'h0, 1'b1, 32'h0, 1'b0);
        access("fault_unalign",  1'b0, 8'h02, MEM_WORD, 32'h0, 1'b1, 32'h0, 1'b0);
        access("fault_range",    1'b0, 8'h24, MEM_WORD, 32'h0, 1'b1, 32'h0, 1'b0);
        access("fault_ro_write", 1'b1, 8'h18, MEM_WORD, 32'h1, 1'b1, 32'h0, 1'b0);
        access("fault_ctrl_byte", 1'b1, 8'h10, MEM_BYTE, 32'h0, 1'b1, 32'h0, 1'b0);
        rd_const("ctrl_after_fault", 8'h10, 32'h0000_0003, 1'b0);

        // Retired-instruction counter.
`ifdef MMIO_TIMER_INSTRET_EN
        exp_instret = 32'd7;
`else
        exp_instret = 32'd0;
`endif
        pulse_idone(7);
        rd_const("instret_lo_7", 8'h18, exp_instret, 1'b0);
        rd_const("instret_hi_0", 8'h1C, 32'h0,       1'b0);

        // Reset during a write drops it.
        rst = 1'b1;
        wr("write_in_reset", 8'h10, 32'h0000_0303);
        rst = 1'b0;
        rd_const("ctrl_after_rst",  8'h10, 32'h0, 1'b0);
        rd_const("mtime_after_rst", 8'h00, 32'h0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) a = 8'($urandom);
            else a = {3'd0, 3'($urandom_range(0, 7)), 2'b00};
            acc = ($urandom_range(0, 9) < 8) ? MEM_WORD : mem_access_t'(2'($urandom_range(0, 2)));
            w   = 1'($urandom_range(0, 1));
            d   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64)) : $urandom;
            if (a == 8'h10) begin
                d[15:8] = 8'($urandom_range(0, 3));
                if (m_en && d[0]) d[15:8] = m_p;
            end
            instruction_done = 1'($urandom_range(0, 1));
            access("random", w, a, acc, d, 1'b0, 32'h0, 1'b0);
            idle(int'($urandom_range(0, 2)), 1'b1);
        end

        idle(3, 1'b0);
        checks++;
        if (q_name.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_name.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
